// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared SPI mode constants and FSM state type for the SPI link
package spi_pkg;

    localparam logic SPI_CPOL = 1'b0;
    localparam logic SPI_CPHA = 1'b0;

    typedef enum logic {
        IDLE,
        ACTIVE
    } spi_state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// rtl/spi_sync_edge.sv - N-stage input synchronizer with rise/fall detection
module spi_sync_edge #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic              dly_q;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            sync_q <= {STAGES{RST_VAL}};
            dly_q  <= RST_VAL;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], din};
            dly_q  <= sync_q[STAGES-1];
        end
    end

    assign dout = sync_q[STAGES-1];
    assign rise = dout & ~dly_q;
    assign fall = ~dout & dly_q;

endmodule

// File: rtl/spi_slave.sv
// rtl/spi_slave.sv - mode-0 SPI slave with one-entry TX holding buffer, oversampled on sys_clk
module spi_slave
    import spi_pkg::*;
#(
    parameter int                DATA_W      = 8,
    parameter int                SYNC_STAGES = 2,
    parameter logic [DATA_W-1:0] IDLE_FILL   = 8'hFF
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              spi_sclk,
    input  logic              spi_cs,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic              spi_miso_oe,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              frame_active,
    output logic              frame_end,
    output logic              tx_underrun
);

    localparam int CNT_W  = $clog2(DATA_W);
    localparam int FILL_W = $clog2(SYNC_STAGES + 1);

    logic sclk_lvl_unused, sclk_rise, sclk_fall;
    logic cs_s, cs_rise, cs_fall;
    logic mosi_s, mosi_rise_unused, mosi_fall_unused;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .din(spi_sclk),
        .dout(sclk_lvl_unused), .rise(sclk_rise), .fall(sclk_fall)
    );
    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .din(spi_cs),
        .dout(cs_s), .rise(cs_rise), .fall(cs_fall)
    );
    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .din(spi_mosi),
        .dout(mosi_s), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
    );

    spi_state_t        state;
    logic              armed;
    logic [FILL_W-1:0] fill_cnt;
    logic [CNT_W-1:0]  bit_cnt;
    logic [DATA_W-2:0] rx_shift;
    logic [DATA_W-1:0] tx_shift;
    logic [DATA_W-1:0] buf_data;
    logic              buf_full;

    logic              start, load, accept;
    logic [DATA_W-1:0] load_byte;

    assign start     = (state == IDLE) && armed && cs_fall;
    assign load      = start || ((state == ACTIVE) && !cs_rise && sclk_fall && (bit_cnt == '0));
    assign load_byte = buf_full ? buf_data : IDLE_FILL;
    assign accept    = tx_valid && !buf_full;
    assign tx_ready  = ~buf_full;
    assign spi_miso_oe = frame_active;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            buf_full <= 1'b0;
            buf_data <= '0;
        end else if (load && buf_full) begin
            buf_full <= 1'b0;
        end else if (accept) begin
            buf_full <= 1'b1;
            buf_data <= tx_data;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state        <= IDLE;
            armed        <= 1'b0;
            fill_cnt     <= '0;
            bit_cnt      <= '0;
            rx_shift     <= '0;
            tx_shift     <= '0;
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            frame_active <= 1'b0;
            frame_end    <= 1'b0;
            tx_underrun  <= 1'b0;
            spi_miso     <= 1'b0;
        end else begin
            rx_valid    <= 1'b0;
            frame_end   <= 1'b0;
            tx_underrun <= load && !buf_full;

            // Arm only once the synchronizer holds real post-reset samples of CS high.
            if (fill_cnt != FILL_W'(SYNC_STAGES))
                fill_cnt <= fill_cnt + FILL_W'(1);
            else if (cs_s)
                armed <= 1'b1;

            if (load) begin
                tx_shift <= load_byte;
                spi_miso <= load_byte[DATA_W-1];
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        state        <= ACTIVE;
                        frame_active <= 1'b1;
                        bit_cnt      <= '0;
                    end
                end
                ACTIVE: begin
                    if (cs_rise) begin
                        state        <= IDLE;
                        frame_active <= 1'b0;
                        frame_end    <= 1'b1;
                        bit_cnt      <= '0;
                        spi_miso     <= 1'b0;
                    end else begin
                        if (sclk_rise) begin
                            rx_shift <= {rx_shift[DATA_W-3:0], mosi_s};
                            if (bit_cnt == CNT_W'(DATA_W - 1)) begin
                                rx_data  <= {rx_shift, mosi_s};
                                rx_valid <= 1'b1;
                                bit_cnt  <= '0;
                            end else begin
                                bit_cnt <= bit_cnt + CNT_W'(1);
                            end
                        end
                        if (sclk_fall && (bit_cnt != '0)) begin
                            tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
                            spi_miso <= tx_shift[DATA_W-2];
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_slave.sv
// tb/tb_spi_slave.sv - directed self-checking bench for spi_slave
module tb_spi_slave;

    logic       sys_clk, sys_rst;
    logic       spi_sclk, spi_cs, spi_mosi, spi_miso, spi_miso_oe;
    logic [7:0] tx_data, rx_data;
    logic       tx_valid, tx_ready, rx_valid, frame_active, frame_end, tx_underrun;

    int total = 0;
    int bad   = 0;
    int n_rx = 0, n_fe = 0, n_un = 0, n_oe = 0;
    int b_rx, b_fe, b_un, b_oe;
    logic [7:0] r, r1, r2, r3;

    spi_slave dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .spi_sclk(spi_sclk), .spi_cs(spi_cs), .spi_mosi(spi_mosi),
        .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid),
        .frame_active(frame_active), .frame_end(frame_end), .tx_underrun(tx_underrun)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) begin
        if (rx_valid)    n_rx <= n_rx + 1;
        if (frame_end)   n_fe <= n_fe + 1;
        if (tx_underrun) n_un <= n_un + 1;
        if (spi_miso_oe) n_oe <= n_oe + 1;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] d);
        int n;
        tx_data  = d;
        tx_valid = 1'b1;
        n = 0;
        while (tx_ready !== 1'b1 && n < 50) begin
            tick(1);
            n++;
        end
        chk("push_ready", {31'd0, tx_ready}, 32'd1);
        tick(1);
        tx_valid = 1'b0;
    endtask

    task automatic spi_xfer(input logic [7:0] b, input int nbits, output logic [7:0] rd);
        rd = 8'h00;
        for (int i = 7; i > 7 - nbits; i--) begin
            spi_mosi = b[i];
            tick(4);
            rd[i] = spi_miso;
            spi_sclk = 1'b1;
            tick(4);
            spi_sclk = 1'b0;
        end
    endtask

    task automatic snap();
        b_rx = n_rx; b_fe = n_fe; b_un = n_un; b_oe = n_oe;
    endtask

    initial begin
        sys_rst = 1'b1; spi_sclk = 1'b0; spi_cs = 1'b1; spi_mosi = 1'b0;
        tx_data = 8'h00; tx_valid = 1'b0;
        tick(3);
        chk("rst_miso",     {31'd0, spi_miso},     32'd0);
        chk("rst_oe",       {31'd0, spi_miso_oe},  32'd0);
        chk("rst_tx_ready", {31'd0, tx_ready},     32'd1);
        chk("rst_rx_data",  {24'd0, rx_data},      32'd0);
        chk("rst_rx_valid", {31'd0, rx_valid},     32'd0);
        chk("rst_active",   {31'd0, frame_active}, 32'd0);
        chk("rst_fend",     {31'd0, frame_end},    32'd0);
        chk("rst_underrun", {31'd0, tx_underrun},  32'd0);
        sys_rst = 1'b0;
        tick(6);

        // single byte
        push(8'hA5);
        chk("t1_full", {31'd0, tx_ready}, 32'd0);
        snap();
        spi_cs = 1'b0;
        tick(4);
        chk("t1_active", {31'd0, frame_active}, 32'd1);
        chk("t1_oe",     {31'd0, spi_miso_oe},  32'd1);
        spi_xfer(8'h3C, 8, r);
        chk("t1_miso", {24'd0, r}, 32'hA5);
        tick(4);
        spi_cs = 1'b1;
        tick(4);
        chk("t1_rx_data", {24'd0, rx_data}, 32'h3C);
        chk("t1_rx_cnt",  n_rx - b_rx, 32'd1);
        chk("t1_fe_cnt",  n_fe - b_fe, 32'd1);
        chk("t1_idle_oe", {31'd0, spi_miso_oe}, 32'd0);
        tick(4);

        // three-byte frame, just-in-time buffering
        push(8'h11);
        snap();
        spi_cs = 1'b0;
        tick(4);
        spi_xfer(8'h5C, 8, r1);
        push(8'h22);
        spi_xfer(8'hE7, 8, r2);
        push(8'h33);
        spi_xfer(8'h81, 8, r3);
        push(8'h44);
        tick(4);
        spi_cs = 1'b1;
        tick(4);
        chk("t2_b0", {24'd0, r1}, 32'h11);
        chk("t2_b1", {24'd0, r2}, 32'h22);
        chk("t2_b2", {24'd0, r3}, 32'h33);
        chk("t2_rx_cnt", n_rx - b_rx, 32'd3);
        chk("t2_un_cnt", n_un - b_un, 32'd0);
        chk("t2_rx_data", {24'd0, rx_data}, 32'h81);
        tick(4);

        // empty buffer at CS fall, accept collides with load
        snap();
        spi_cs = 1'b0;
        tick(2);
        tx_data  = 8'h5A;
        tx_valid = 1'b1;
        tick(1);
        tx_valid = 1'b0;
        chk("t3_underrun", {31'd0, tx_underrun}, 32'd1);
        chk("t3_buffered", {31'd0, tx_ready},    32'd0);
        spi_xfer(8'h96, 8, r1);
        spi_xfer(8'h69, 8, r2);
        chk("t3_un_cnt", n_un - b_un, 32'd1);
        chk("t3_b0", {24'd0, r1}, 32'hFF);
        chk("t3_b1", {24'd0, r2}, 32'h5A);
        tick(4);
        spi_cs = 1'b1;
        tick(4);
        chk("t3_rx_data", {24'd0, rx_data}, 32'h69);
        tick(4);

        // partial byte discarded, next frame realigned
        snap();
        spi_cs = 1'b0;
        tick(4);
        spi_xfer(8'hC3, 5, r);
        tick(4);
        spi_cs = 1'b1;
        tick(4);
        chk("t4_rx_cnt",  n_rx - b_rx, 32'd0);
        chk("t4_fe_cnt",  n_fe - b_fe, 32'd1);
        chk("t4_rx_hold", {24'd0, rx_data}, 32'h69);
        tick(4);
        push(8'h3A);
        spi_cs = 1'b0;
        tick(4);
        spi_xfer(8'hD2, 8, r);
        chk("t4_miso", {24'd0, r}, 32'h3A);
        tick(4);
        spi_cs = 1'b1;
        tick(4);
        chk("t4_rx_data", {24'd0, rx_data}, 32'hD2);
        tick(4);

        // reset mid-byte with CS held low
        spi_cs = 1'b0;
        tick(4);
        spi_xfer(8'hAA, 3, r);
        push(8'h77);
        sys_rst = 1'b1;
        tick(1);
        sys_rst = 1'b0;
        chk("t5_tx_ready", {31'd0, tx_ready},     32'd1);
        chk("t5_oe",       {31'd0, spi_miso_oe},  32'd0);
        chk("t5_active",   {31'd0, frame_active}, 32'd0);
        chk("t5_rx_data",  {24'd0, rx_data},      32'd0);
        chk("t5_miso",     {31'd0, spi_miso},     32'd0);
        snap();
        spi_xfer(8'h55, 8, r);
        tick(4);
        chk("t5_dead_rx",  n_rx - b_rx, 32'd0);
        chk("t5_dead_oe",  n_oe - b_oe, 32'd0);
        chk("t5_dead_fe",  n_fe - b_fe, 32'd0);
        chk("t5_dead_mis", {24'd0, r}, 32'd0);
        spi_cs = 1'b1;
        tick(6);
        push(8'h4B);
        snap();
        spi_cs = 1'b0;
        tick(4);
        spi_xfer(8'h2D, 8, r);
        chk("t5_miso_new", {24'd0, r}, 32'h4B);
        tick(4);
        spi_cs = 1'b1;
        tick(4);
        chk("t5_rx_new", {24'd0, rx_data}, 32'h2D);
        chk("t5_rx_cnt", n_rx - b_rx, 32'd1);
        tick(4);

        // SCLK activity with CS high
        snap();
        spi_xfer(8'hF0, 8, r);
        tick(4);
        chk("t6_rx_cnt", n_rx - b_rx, 32'd0);
        chk("t6_oe_cyc", n_oe - b_oe, 32'd0);
        chk("t6_rx_hold", {24'd0, rx_data}, 32'h2D);
        chk("t6_miso", {24'd0, r}, 32'd0);
        chk("t6_active", {31'd0, frame_active}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
